// File: rtl/dmem_word_reader.sv
// Read port for the flip-flop Y86-64 data memory: fetches eight bytes one per
// cycle and returns them as a little-endian quad word with a valid/ready handshake.
//
// state  | meaning
// S_IDLE | waiting for a load request, req_ready high
// S_READ | strobing the byte array, one byte per cycle, cnt 0..7
// S_RESP | response presented, held until rsp_ready
module dmem_word_reader #(
    parameter int MEM_BYTES = 1024,
    parameter int ADDR_W    = 10
) (
    input  logic              clk,
    input  logic              async_reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [63:0]       req_addr,
    output logic              byte_rd_en,
    output logic [ADDR_W-1:0] byte_rd_addr,
    input  logic [7:0]        byte_rd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [63:0]       rsp_data,
    output logic              rsp_error
);

    localparam logic [63:0] LAST_WORD = 64'(MEM_BYTES - 8);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [ADDR_W-1:0] r_base;
    logic [2:0]        r_cnt;
    logic [63:0]       r_rsp_data;
    logic              r_rsp_error;

    logic              w_accept;
    logic              w_addr_bad;
    logic              w_last;
    logic [5:0]        w_bit_idx;

    // Full 64-bit compare so addresses near 2**64 cannot wrap into range.
    assign w_addr_bad = (req_addr > LAST_WORD);
    assign w_accept   = (r_state == S_IDLE) && req_valid;
    assign w_last     = (r_cnt == 3'd7);
    assign w_bit_idx  = {r_cnt, 3'b000};

    always_ff @(posedge clk or negedge async_reset) begin
        if (!async_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_next_state = w_addr_bad ? S_RESP : S_READ;
                end
            end
            S_READ: begin
                if (w_last) begin
                    w_next_state = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready    = 1'b0;
        byte_rd_en   = 1'b0;
        byte_rd_addr = '0;
        rsp_valid    = 1'b0;
        case (r_state)
            S_IDLE: req_ready = 1'b1;
            S_READ: begin
                byte_rd_en   = 1'b1;
                byte_rd_addr = r_base + {{(ADDR_W-3){1'b0}}, r_cnt};
            end
            S_RESP: rsp_valid = 1'b1;
            default: req_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge async_reset) begin
        if (!async_reset) begin
            r_base      <= '0;
            r_cnt       <= 3'd0;
            r_rsp_data  <= 64'd0;
            r_rsp_error <= 1'b0;
        end else if (w_accept) begin
            r_base      <= req_addr[ADDR_W-1:0];
            r_cnt       <= 3'd0;
            r_rsp_data  <= 64'd0;
            r_rsp_error <= w_addr_bad;
        end else if (r_state == S_READ) begin
            r_rsp_data[w_bit_idx +: 8] <= byte_rd_data;
            r_cnt                      <= r_cnt + 3'd1;
        end
    end

    assign rsp_data  = r_rsp_data;
    assign rsp_error = r_rsp_error;

endmodule
